rv_fetch_unit: RTL and testbench

// - Instruction fetch stage upstream of the core's decode/execute pipeline (top-level core consumes pc/instr).
// - Issues sequential word reads to instruction memory, buffers returned {pc, instr} pairs in a small FIFO.
// - Presents them to decode over a valid/ready handshake; branch/jump redirects flush the FIFO and discard in-flight responses.

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/rv_fetch_unit.sv | 127 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared types and constants for the instruction fetch slice.
//   XLEN          address/datapath width used by the fetch unit and its FIFO
//   fetch_entry_t one buffered fetch result: {pc, instr}
//   INSTR_NOP     canonical RV32I nop (addi x0, x0, 0)
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t used to buffer fetched
// instructions between instruction memory and decode.
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   push   in   write wdata at the tail (ignored when full, unless popping)
//   pop    in   drop the head entry (ignored when empty)
//   flush  in   discard all entries; overrides push/pop
//   wdata  in   entry to write
//   rdata  out  head entry (meaningful only when !empty)
//   count  out  number of valid entries, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (do_push && !(rst || flush)) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction fetch stage.
// Issues sequential word reads to instruction memory under a credit limit,
// buffers returned {pc, instr} pairs in fetch_fifo and hands them to decode
// over valid/ready. A redirect flushes the buffer and drops every response
// still in flight.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/ready/addr         word-aligned fetch requests
//   imem_resp_valid/data              in-order responses, never back-pressured
//   redirect_valid/redirect_pc        control-flow change from execute
//   if_valid/if_ready/if_pc/if_instr  head instruction towards decode
//   perf_fetched/perf_dropped         only with FETCH_PERF_EN defined
// XLEN comes from rv_pkg so that the FIFO entry type and this block agree.
// Optional feature macro: FETCH_PERF_EN adds the two 32-bit perf counters.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [XLEN-1:0]  if_pc,
    output logic [31:0]      if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_dropped
`endif
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;
    logic [CW:0]      committed;
    logic [XLEN-1:0]  redirect_tgt;
    logic             req_fire;
    logic             resp_push;
    logic             if_pop;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    // Every slot is reserved at request time, so buffered plus in-flight
    // words never exceed the FIFO depth and responses need no backpressure.
    assign committed      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && !fifo_full
                            && (committed < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses belonging to pre-redirect requests are swallowed here,
    // including one arriving in the redirect cycle itself.
    assign resp_push  = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign if_pop     = if_valid && if_ready && !redirect_valid;
    assign fifo_wdata = '{pc: resp_pc, instr: imem_resp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_push),
        .pop   (if_pop),
        .flush (redirect_valid),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = if_valid ? fifo_head.pc    : '0;
    assign if_instr = if_valid ? fifo_head.instr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // No request fires this cycle, so everything still in flight
                // after this cycle's response is stale.
                fetch_pc <= redirect_tgt;
                resp_pc  <= redirect_tgt;
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_resp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + XLEN'(4);
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (resp_push)                       perf_fetched <= perf_fetched + 32'd1;
            if (imem_resp_valid && !resp_push)   perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed scenarios against a queue-based reference of the
// fetch unit (epoch-tagged memory requests, instruction queue towards decode).
module tb_rv_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    rv_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_dropped    (perf_dropped)
`endif
    );

    typedef struct { logic [31:0] addr; int ep; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        memq[$];
    ent_t        mq[$];
    int          ep = 0;
    logic [31:0] m_addr = RESET_PC;
    int          cyc = 0;
    int          lat = 1;
    int          m_pushed = 0;
    int          m_dropped = 0;
    bit          armed = 0;

    logic [31:0] log_pc[$];
    int          log_cyc[$];
    int          dut_fires = 0;
    logic [31:0] exp_q[$];

    int nvec = 0;
    int nerr = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic m_req_valid();
        return !rst && !redirect_valid && ((memq.size() + mq.size()) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input logic [31:0] exp[$]);
        chk({name, "_len_ok"}, 64'(log_pc.size() >= exp.size()), 64'd1);
        for (int k = 0; k < exp.size(); k++)
            if (k < log_pc.size())
                chk($sformatf("%s[%0d]", name, k), log_pc[k], exp[k]);
    endtask

    // Compare process: DUT against the reference, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("imem_req_valid", imem_req_valid, m_req_valid());
            chk("imem_req_addr", imem_req_addr, m_addr);
            chk("if_valid", if_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("if_pc", if_pc, mq[0].pc);
                chk("if_instr", if_instr, mq[0].instr);
            end else if (rst) begin
                chk("rst_if_pc", if_pc, 0);
                chk("rst_if_instr", if_instr, 0);
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, 32'(m_pushed));
            chk("perf_dropped", perf_dropped, 32'(m_dropped));
`endif
            if (!rst && imem_req_valid && imem_req_ready) dut_fires++;
            if (!rst && if_valid && if_ready && !redirect_valid) begin
                log_pc.push_back(if_pc);
                log_cyc.push_back(cyc);
            end
        end
    end

    // Reference update plus memory stub (drives responses 1 time unit after the edge).
    bit   u_fire, u_resp;
    req_t u_r, u_n;
    ent_t u_e;
    always @(posedge clk) begin
        if (rst) begin
            memq.delete();
            mq.delete();
            ep = 0;
            m_addr = RESET_PC;
            cyc = 0;
            m_pushed = 0;
            m_dropped = 0;
            armed = 1;
        end else begin
            u_fire = m_req_valid() && imem_req_ready;
            u_resp = imem_resp_valid && (memq.size() != 0);
            if (u_resp) u_r = memq.pop_front();
            if (redirect_valid) begin
                ep++;
                mq.delete();
                m_addr = redirect_pc & ~32'h3;
            end else if (mq.size() != 0 && if_ready) begin
                mq.delete(0);
            end
            if (u_resp) begin
                if (u_r.ep == ep) begin
                    u_e.pc = u_r.addr;
                    u_e.instr = mem_word(u_r.addr);
                    mq.push_back(u_e);
                    m_pushed++;
                end else begin
                    m_dropped++;
                end
            end
            if (u_fire) begin
                u_n.addr = m_addr;
                u_n.ep = ep;
                u_n.due = cyc + lat;
                memq.push_back(u_n);
                m_addr = m_addr + 32'd4;
            end
            cyc++;
        end
        #1;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        imem_req_ready = 1'b0;
        step();
        step();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc_lit", if_pc, 0);
        chk("rst_if_instr_lit", if_instr, 0);
        log_pc.delete();
        log_cyc.delete();
        dut_fires = 0;
        rst = 1'b0;
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
    endtask

    initial begin
        // Streaming with 1-cycle memory: one instruction per cycle from cycle 2.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        repeat (8) step();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        chk_log("stream_pc", exp_q);
        for (int k = 0; k < 4; k++)
            if (k < log_cyc.size()) chk($sformatf("stream_cyc[%0d]", k), 64'(log_cyc[k]), 64'(k + 2));

        // Backpressure: exactly DEPTH requests, then stall; drain in order.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        if_ready = 1'b0;
        repeat (10) step();
        chk("bp_fires", 64'(dut_fires), 64'd4);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_if_valid", if_valid, 1);
        chk("bp_if_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        repeat (8) step();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        chk_log("bp_drain_pc", exp_q);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        repeat (10) step();
        exp_q = '{32'h100, 32'h104};
        chk_log("redir_pc", exp_q);
        if (log_cyc.size() > 0) chk("redir_first_cyc", 64'(log_cyc[0]), 64'd7);
`ifdef FETCH_PERF_EN
        chk("perf_dropped_lit", perf_dropped, 32'd2);
        chk("perf_fetched_sum", perf_fetched, 32'(log_pc.size() + mq.size()));
`endif

        // Redirect coinciding with a response and a pop, then back-to-back
        // redirects with the last one landing near the top of the address space.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            redirect_valid = (i == 6) || (i == 12) || (i == 13);
            redirect_pc = (i == 6) ? 32'h201 : (i == 12) ? 32'h300 : 32'hFFFF_FFF9;
            step();
        end
        redirect_valid = 1'b0;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204, 32'h208,
                  32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        chk_log("flush_pc", exp_q);
        if (log_cyc.size() > 7) begin
            chk("flush_cyc_200", 64'(log_cyc[4]), 64'd9);
            chk("flush_cyc_wrap", 64'(log_cyc[7]), 64'd16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
